mem_reader: RTL and testbench
=============================

# mem_reader

Streaming read-out engine for the valid-tracked dual-port memory. On a `start` pulse it sweeps every memory address from 0 to 2^A-1 through the memory's registered read port. Each read word is delivered on a valid/ready output stream with its index. The block absorbs the one-cycle read latency and any downstream backpressure without losing or duplicating words. It sits between the memory's read port and the consumer, for example a display or serializer path.

## Interface
- `A`, default 9: memory address width; the sweep covers 2^A entries.
- `S`, default 24: data word width.

- `clock`  input  1  single clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `start`  input  1  single-cycle request to begin a sweep.
- `busy`  output  1  high from the cycle after an accepted `start` until `done`, inclusive.
- `done`  output  1  one-cycle pulse after the final output handshake.
- `mem_address`  output  A  drives the memory read address.
- `mem_data`  input  S  memory read data; valid exactly one clock after `mem_address` is presented.
- `out_data`  output  S  streamed word.
- `out_index`  output  A  address the word was read from.
- `out_valid`  output  1  stream valid.
- `out_ready`  input  1  stream ready from the consumer.
- `out_last`  output  1  high on the beat whose `out_index` = 2^A-1.

## Operation
- The FSM has three states: IDLE, SCAN and DRAIN.
- IDLE:
  - `start`=1 moves to SCAN and clears the issue counter and the in-flight flag.
  - `start` is ignored in SCAN and DRAIN.
- SCAN issues one read per cycle while (buffer occupancy + in-flight reads) < 2.
  - Each issue drives `mem_address` = issue counter, sets in-flight, and increments the counter.
  - The cycle after an issue, `mem_data` is written into the buffer tagged with its address.
  - After address 2^A-1 is issued, the FSM goes to DRAIN. The counter does not wrap and no further reads are issued.
- The output buffer is a 2-entry FIFO.
  - The head entry drives `out_data`, `out_index` and `out_last`.
  - `out_valid` = buffer not empty.
  - The head is popped when `out_valid` and `out_ready` are both high.
  - A push and a pop in the same cycle are both honoured, and occupancy is unchanged.
- DRAIN: when the buffer is empty and nothing is in flight, pulse `done`, drop `busy` in the following cycle, and return to IDLE.
- Backpressure:
  - `out_data` and `out_index` are held stable while `out_valid`=1 and `out_ready`=0.
  - No read is issued that could overflow the buffer.
- When `mem_address` is not being issued, it holds its last value. The memory tolerates idle reads.
- Reset assertion at any time, including mid-sweep:
  - The FSM returns to IDLE and the buffer and in-flight flag are cleared.
  - All outputs go to 0: `busy`, `done`, `out_valid`, `out_last`, `out_data`, `out_index` and `mem_address`.
  - The sweep is abandoned and no `done` pulse is produced.

## Timing
- Cycle 0: `start` is sampled high.
- Cycle 1: `busy`=1 and `mem_address`=0.
- Cycle 3: first `out_valid`=1. First-beat latency is 3 clocks from `start`.
- Throughput is 1 word/clock while `out_ready` is held high.
  - A full sweep with `out_ready` constantly high: last handshake in cycle 2^A+2, `done` in cycle 2^A+3, `busy` low from cycle 2^A+4.
- A `start` arriving in the same cycle as `done` is ignored.
- A `start` arriving in the cycle after `done` is accepted.

## Configuration
- `MEM_READER_SKIP_ZERO_EN`
  - Defined: words with `mem_data` = 0 (unwritten or cleared entries) are discarded at buffer write and never appear on the stream.
    - `out_last` still fires only on index 2^A-1. If that word is zero, no beat carries `out_last`, and `done` alone marks completion.
    - Issue gating is unchanged.
  - Not defined: every address produces exactly one beat, zero words included.

## Test plan
Unless stated otherwise, tests use A=3, S=8, memory contents 0x10,0x11,…,0x17, and macro off.
- Reset then `start`, `out_ready`=1 constantly:
  - 8 beats, indices 0..7, data 0x10..0x17.
  - `out_last` on index 7 only.
  - `done` in cycle 11.
- `out_ready` toggling 1,0,0,1 repeating:
  - Same 8 beats in order, none dropped or repeated.
  - `out_data` stable during stalls.
  - Buffer never exceeds 2 entries.
- `start` re-pulsed at cycle 5 of a sweep: ignored, and exactly 8 beats are produced.
- Reset asserted at cycle 6 of a sweep:
  - All outputs 0 immediately and no `done`.
  - A subsequent `start` yields a full fresh sweep from index 0.
- Macro on, with entries 2, 5 and 7 equal to 0:
  - Beats with indices 0,1,3,4,6 only.
  - No `out_last`.
  - `done` still pulses once.
- `out_ready`=0 for 20 cycles after `start`:
  - Exactly 2 words buffered, `mem_address` stuck at 1.
  - Stream then resumes correctly when `out_ready` rises.

Source files
------------

// File: rtl/mem_reader.sv
// -----------------------------------------------------------------------------
// mem_reader
//
// Sweeps every address 0 .. 2^A-1 of a memory with a one-cycle registered read
// port and streams each word, tagged with its address, on a valid/ready
// interface. A 2-entry output FIFO absorbs the read latency and any consumer
// backpressure, so no word is lost or duplicated.
//
// Parameters
//   A            memory address width (sweep length 2^A)
//   S            data word width
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous active-low reset
//   start        single-cycle sweep request (honoured only while idle)
//   busy         high from the cycle after an accepted start through done
//   done         one-cycle pulse once the last word has left the block
//   mem_address  memory read address
//   mem_data     memory read data, valid one clock after mem_address
//   out_data     streamed word
//   out_index    address the streamed word came from
//   out_valid    stream valid (FIFO not empty)
//   out_ready    stream ready from the consumer
//   out_last     marks the beat whose index is 2^A-1
//
// Build option
//   MEM_READER_SKIP_ZERO_EN  when defined, zero words are dropped at the FIFO
//                            write and never appear on the stream.
// -----------------------------------------------------------------------------
module mem_reader #(
   parameter int A = 9,
   parameter int S = 24
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic [A-1:0] mem_address,
   input  logic [S-1:0] mem_data,
   output logic [S-1:0] out_data,
   output logic [A-1:0] out_index,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

   state_t       state, state_nxt;
   logic [A-1:0] issue_cnt;
   logic         issue;
   logic         issue_last;
   logic         rd_vld_p1;
   logic [A-1:0] rd_addr_p1;
   logic         push;
   logic         pop;
   logic [1:0]   occ;
   logic [2:0]   used_slots;
   logic [S-1:0] head_data, tail_data;
   logic [A-1:0] head_index, tail_index;

   assign issue_last = (issue_cnt == {A{1'b1}});
   assign out_valid  = (occ != 2'd0);
   assign pop        = out_valid & out_ready;

   // A slot freed by this cycle's pop can be reused by this cycle's issue;
   // without that credit the stream could not sustain one word per clock.
   assign used_slots = {1'b0, occ} + {2'b00, rd_vld_p1} - {2'b00, pop};

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SCAN;
         SCAN:    if (issue && issue_last) state_nxt = DRAIN;
         DRAIN:   if ((occ == 2'd0) && !rd_vld_p1) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy  = (state != IDLE);
      done  = (state == DRAIN) && (occ == 2'd0) && !rd_vld_p1;
      issue = (state == SCAN) && (used_slots < 3'd2);
   end

   // Address stays on the last issued value between issues.
   assign mem_address = issue ? issue_cnt : rd_addr_p1;

   // Stage p0 -> p1: read issued, data returns from memory next cycle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         issue_cnt  <= '0;
         rd_vld_p1  <= 1'b0;
         rd_addr_p1 <= '0;
      end else begin
         if (state == IDLE) begin
            rd_vld_p1 <= 1'b0;
            if (start) issue_cnt <= '0;
         end else begin
            rd_vld_p1 <= issue;
            if (issue) begin
               rd_addr_p1 <= issue_cnt;
               // Counter parks on the final address instead of wrapping.
               if (!issue_last) issue_cnt <= issue_cnt + A'(1);
            end
         end
      end
   end

`ifdef MEM_READER_SKIP_ZERO_EN
   assign push = rd_vld_p1 && (mem_data != '0);
`else
   assign push = rd_vld_p1;
`endif

   // Stage p1 -> output FIFO: head entry drives the stream
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         occ        <= 2'd0;
         head_data  <= '0;
         head_index <= '0;
         tail_data  <= '0;
         tail_index <= '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) begin
                  head_data  <= mem_data;
                  head_index <= rd_addr_p1;
               end else begin
                  tail_data  <= mem_data;
                  tail_index <= rd_addr_p1;
               end
               occ <= occ + 2'd1;
            end
            2'b01: begin
               head_data  <= tail_data;
               head_index <= tail_index;
               occ        <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  head_data  <= mem_data;
                  head_index <= rd_addr_p1;
               end else begin
                  head_data  <= tail_data;
                  head_index <= tail_index;
                  tail_data  <= mem_data;
                  tail_index <= rd_addr_p1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign out_data  = head_data;
   assign out_index = head_index;
   assign out_last  = out_valid && (head_index == {A{1'b1}});

endmodule

// File: tb/tb_mem_reader.sv
module tb_mem_reader;
   localparam int A = 3;
   localparam int S = 8;

   logic         clock = 1'b0;
   logic         reset;
   logic         start;
   logic         busy;
   logic         done;
   logic [A-1:0] mem_address;
   logic [S-1:0] mem_data;
   logic [S-1:0] out_data;
   logic [A-1:0] out_index;
   logic         out_valid;
   logic         out_ready;
   logic         out_last;

   logic [S-1:0] mem [8];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [A-1:0] idx;
      logic [S-1:0] data;
      logic         last;
   } beat_t;

   typedef struct {
      logic         st;
      logic         rdy;
      logic         busy;
      logic         done;
      logic         valid;
      logic         last;
      logic [A-1:0] addr;
      logic [A-1:0] idx;
      logic [S-1:0] data;
   } vec_t;

   beat_t        beats[$];
   beat_t        mon_beat;
   int           done_cnt = 0;
   logic         prev_stall = 1'b0;
   logic [S-1:0] prev_data;
   logic [A-1:0] prev_idx;

   always #5 clock = ~clock;

   // Registered read port: data follows the address by one clock.
   always @(posedge clock) mem_data <= mem[mem_address];

   mem_reader #(.A(A), .S(S)) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .out_data    (out_data),
      .out_index   (out_index),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Stream monitor: collects handshakes, counts done pulses, checks hold.
   always @(negedge clock) begin
      if (!reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            checks++;
            if (!(out_valid && out_data == prev_data && out_index == prev_idx)) begin
               errors++;
               $display("FAIL stall_hold: got valid=%0b idx=%0d data=%02h, required valid=1 idx=%0d data=%02h",
                        out_valid, out_index, out_data, prev_idx, prev_data);
            end
         end
         if (out_valid && out_ready) begin
            mon_beat.idx  = out_index;
            mon_beat.data = out_data;
            mon_beat.last = out_last;
            beats.push_back(mon_beat);
         end
         if (done) done_cnt++;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_idx   = out_index;
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic rdy(input int mode, input int c);
      case (mode)
         1:       return (c % 4 == 0) || (c % 4 == 3);
         2:       return (c > 20);
         default: return 1'b1;
      endcase
   endfunction

   task automatic check_beats(input string name, input logic [7:0] skip_mask);
      int j = 0;
      for (int i = 0; i < 8; i++) begin
         if (!skip_mask[i]) begin
            if (j < beats.size())
               check($sformatf("%s_beat%0d", name, j),
                     {beats[j].idx, beats[j].data, beats[j].last},
                     {3'(i), 8'h10 + 8'(i), (i == 7)});
            j++;
         end
      end
      check($sformatf("%s_count", name), beats.size(), j);
   endtask

   task automatic run_sweep(input int mode, input int restart_at, output int dcyc);
      beats.delete();
      done_cnt = 0;
      dcyc = -1;
      step();
      start = 1'b1;
      out_ready = rdy(mode, 0);
      for (int c = 1; c <= 200; c++) begin
         step();
         start = (c == restart_at);
         out_ready = rdy(mode, c);
         @(negedge clock);
         if (mode == 2 && (c == 3 || c == 20)) begin
            check($sformatf("bp_addr_c%0d", c), mem_address, 3'd1);
            check($sformatf("bp_head_c%0d", c), {out_valid, out_index, out_data}, {1'b1, 3'd0, 8'h10});
         end
         if (done) begin
            dcyc = c;
            break;
         end
      end
      start = 1'b0;
      if (dcyc < 0) begin
         checks++;
         errors++;
         $display("FAIL sweep_timeout: got no done, required done within 200 cycles");
      end
      step();
      @(negedge clock);
      check("busy_after_done", busy, 1'b0);
   endtask

   initial begin
      vec_t tbl[13];
      int   d;

      // Full sweep with out_ready high: cycle 0 is the start cycle.
      //           st rdy busy done vld last addr idx data
      tbl[0]  = '{1, 1, 0, 0, 0, 0, 3'd0, 3'd0, 8'h00};
      tbl[1]  = '{0, 1, 1, 0, 0, 0, 3'd0, 3'd0, 8'h00};
      tbl[2]  = '{0, 1, 1, 0, 0, 0, 3'd1, 3'd0, 8'h00};
      tbl[3]  = '{0, 1, 1, 0, 1, 0, 3'd2, 3'd0, 8'h10};
      tbl[4]  = '{0, 1, 1, 0, 1, 0, 3'd3, 3'd1, 8'h11};
      tbl[5]  = '{0, 1, 1, 0, 1, 0, 3'd4, 3'd2, 8'h12};
      tbl[6]  = '{0, 1, 1, 0, 1, 0, 3'd5, 3'd3, 8'h13};
      tbl[7]  = '{0, 1, 1, 0, 1, 0, 3'd6, 3'd4, 8'h14};
      tbl[8]  = '{0, 1, 1, 0, 1, 0, 3'd7, 3'd5, 8'h15};
      tbl[9]  = '{0, 1, 1, 0, 1, 0, 3'd7, 3'd6, 8'h16};
      tbl[10] = '{0, 1, 1, 0, 1, 1, 3'd7, 3'd7, 8'h17};
      tbl[11] = '{0, 1, 1, 1, 0, 0, 3'd7, 3'd0, 8'h00};
      tbl[12] = '{0, 1, 0, 0, 0, 0, 3'd7, 3'd0, 8'h00};

      for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);

      reset = 1'b0;
      start = 1'b0;
      out_ready = 1'b0;
      repeat (3) step();
      @(negedge clock);
      check("reset_state",
            {busy, done, out_valid, out_last, mem_address, out_index, out_data}, '0);

      step();
      reset = 1'b1;
      beats.delete();
      done_cnt = 0;

      // Table-driven full sweep
      for (int r = 0; r < 13; r++) begin
         step();
         start = tbl[r].st;
         out_ready = tbl[r].rdy;
         @(negedge clock);
         check($sformatf("sweep_c%0d", r),
               {busy, done, out_valid, out_last, mem_address,
                out_valid ? out_index : 3'd0, out_valid ? out_data : 8'h00},
               {tbl[r].busy, tbl[r].done, tbl[r].valid, tbl[r].last, tbl[r].addr,
                tbl[r].idx, tbl[r].data});
      end
      start = 1'b0;
      check_beats("sweep", 8'h00);
      check("sweep_done_cnt", done_cnt, 1);

      // out_ready toggling 1,0,0,1
      run_sweep(1, -1, d);
      check_beats("toggle", 8'h00);
      check("toggle_done_cnt", done_cnt, 1);

      // start re-pulsed mid-sweep is ignored
      run_sweep(0, 5, d);
      check("restart_done_cyc", d, 11);
      repeat (10) step();
      @(negedge clock);
      check_beats("restart", 8'h00);
      check("restart_busy_idle", busy, 1'b0);
      check("restart_done_cnt", done_cnt, 1);

      // Reset asserted at cycle 6 of a sweep
      beats.delete();
      done_cnt = 0;
      step();
      start = 1'b1;
      out_ready = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         step();
         start = 1'b0;
      end
      reset = 1'b0;
      #1;
      check("midreset_outputs",
            {busy, done, out_valid, out_last, mem_address, out_index, out_data}, '0);
      repeat (3) step();
      reset = 1'b1;
      repeat (5) step();
      @(negedge clock);
      check("midreset_no_done", done_cnt, 0);
      check("midreset_idle", busy, 1'b0);
      run_sweep(0, -1, d);
      check_beats("fresh", 8'h00);
      check("fresh_done_cyc", d, 11);

      // out_ready low for 20 cycles after start
      run_sweep(2, -1, d);
      check_beats("bp", 8'h00);
      check("bp_done_cyc", d, 29);

      // start in the done cycle is ignored, start one cycle later is accepted
      step();
      start = 1'b1;
      out_ready = 1'b1;
      for (int c = 1; c <= 11; c++) begin
         step();
         start = (c == 11);
         @(negedge clock);
      end
      check("done_cycle_pulse", done, 1'b1);
      step();
      start = 1'b1;
      @(negedge clock);
      check("start_in_done_ignored", busy, 1'b0);
      step();
      start = 1'b0;
      beats.delete();
      done_cnt = 0;
      @(negedge clock);
      check("start_after_done_taken", {busy, mem_address}, {1'b1, 3'd0});
      d = -1;
      for (int c = 14; c <= 60; c++) begin
         step();
         @(negedge clock);
         if (done) begin
            d = c;
            break;
         end
      end
      check("post_done_sweep_done_cyc", d, 23);
      check_beats("post_done_sweep", 8'h00);

`ifdef MEM_READER_SKIP_ZERO_EN
      // Zero words skipped: entries 2, 5, 7 cleared
      mem[2] = 8'h00;
      mem[5] = 8'h00;
      mem[7] = 8'h00;
      run_sweep(0, -1, d);
      check_beats("skip", 8'b1010_0100);
      check("skip_done_cnt", done_cnt, 1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
